// File: rtl/nn_fixed_pkg.sv
// Shared sign-magnitude fixed-point types and helpers for the neuron datapath.
// Bit N-1 is the sign, bits N-2:0 are the magnitude, and the low FX_Q bits are fraction.
package nn_fixed_pkg;
   localparam int FX_Q = 15;
   localparam int FX_N = 32;

   typedef logic [FX_N-1:0] fx_t;

   typedef enum logic [1:0] {
      ACT_NONE  = 2'd0,
      ACT_RELU  = 2'd1,
      ACT_CLAMP = 2'd2
   } act_e;

   localparam fx_t FX_ONE = fx_t'(1) << FX_Q;

   // A zero magnitude always carries a positive sign.
   function automatic fx_t sm_neg_zero_fix(input fx_t v);
      return (v[FX_N-2:0] == '0) ? '0 : v;
   endfunction
endpackage

// File: rtl/sm_sat_add.sv
// Combinational saturating sign-magnitude adder; a drop-in replacement for qadd.
// Zero latency; never produces negative zero.
module sm_sat_add #(
   parameter int Q = 15,
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum
);
   if (Q < 0 || Q > N - 2) begin : g_bad_q
      $error("sm_sat_add: Q out of range for N");
   end

   logic         sa;
   logic         sb;
   logic [N-2:0] ma;
   logic [N-2:0] mb;
   logic [N-1:0] msum;
   logic [N-2:0] mag;
   logic         sgn;

   always_comb begin
      sa   = a[N-1];
      sb   = b[N-1];
      ma   = a[N-2:0];
      mb   = b[N-2:0];
      msum = {1'b0, ma} + {1'b0, mb};
      mag  = '0;
      sgn  = 1'b0;
      if (sa == sb) begin
         // The carry out of the magnitude field means the result is out of range.
         sgn = sa;
         mag = msum[N-1] ? '1 : msum[N-2:0];
      end else if (ma >= mb) begin
         sgn = sa;
         mag = ma - mb;
      end else begin
         sgn = sb;
         mag = mb - ma;
      end
      if (mag == '0) sgn = 1'b0;
      sum = {sgn, mag};
   end
endmodule

// File: rtl/neuron_bias_act.sv
// Captures dot-product results, adds the bias, applies the activation, and queues the results.
// 3-cycle capture-to-valid latency; the pipeline never stalls; a push to a full FIFO is dropped and sets overflow.
module neuron_bias_act
   import nn_fixed_pkg::*;
#(
   parameter int Q     = FX_Q,
   parameter int N     = FX_N,
   parameter int ACT   = 1,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] dot_result,
   input  logic         dot_done,
   input  logic [N-1:0] bias,
   output logic [N-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   input  logic         clear_ovf,
   output logic         overflow,
   output logic         busy
);
   localparam int           AW       = $clog2(DEPTH);
   localparam act_e         ACT_MODE = act_e'(ACT[1:0]);
   localparam logic [N-2:0] LIM      = {{(N-2){1'b0}}, 1'b1} << Q;

   logic         done_q;
   logic         cap;
   logic         v0, v1, v2;
   logic [N-1:0] d0, b0, s1, s2;
   logic [N-1:0] sum;
   logic [N-1:0] act_val;

   assign cap = dot_done & ~done_q;

   sm_sat_add #(.Q(Q), .N(N)) u_add (
      .a   (d0),
      .b   (b0),
      .sum (sum)
   );

   always_comb begin
      act_val = s1;
      case (ACT_MODE)
         ACT_RELU:  if (s1[N-1]) act_val = '0;
         ACT_CLAMP: if (s1[N-2:0] > LIM) act_val = {s1[N-1], LIM};
         default:   act_val = s1;
      endcase
   end

   // done_q resets high so a dot_done already asserted at reset release is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b1;
         v0     <= 1'b0;
         v1     <= 1'b0;
         v2     <= 1'b0;
         d0     <= '0;
         b0     <= '0;
         s1     <= '0;
         s2     <= '0;
      end else begin
         done_q <= dot_done;
         v0     <= cap;
         v1     <= v0;
         v2     <= v1;
         if (cap) begin
            d0 <= dot_result;
            b0 <= bias;
         end
         if (v0) s1 <= sum;
         if (v1) s2 <= act_val;
      end
   end

   assign busy = v0 | v1 | v2;

   logic [N-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;
   logic [N-1:0]  last_q;
   logic          pop, full, push_ok, drop;

   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   assign full      = (count == DEPTH[AW:0]);
   assign push_ok   = v2 & (~full | pop);
   assign drop      = v2 & full & ~pop;
   assign out_data  = out_valid ? mem[rptr] : last_q;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= sm_neg_zero_fix(s2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         last_q   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop) begin
            rptr   <= rptr + 1'b1;
            last_q <= mem[rptr];
         end
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) overflow <= 1'b1;
         else if (clear_ovf) overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_neuron_bias_act.sv
// Directed bench: three instances (ACT = 0, 1, 2) share one stimulus stream.
// Each instance is compared against hand-computed Q15 sign-magnitude results.
module tb_neuron_bias_act;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] dot_result;
   logic        dot_done;
   logic [31:0] bias;
   logic        out_ready;
   logic        clear_ovf;
   logic [31:0] out_data  [3];
   logic        out_valid [3];
   logic        overflow  [3];
   logic        busy      [3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      neuron_bias_act #(.Q(15), .N(32), .ACT(g), .DEPTH(4)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .dot_result (dot_result),
         .dot_done   (dot_done),
         .bias       (bias),
         .out_data   (out_data[g]),
         .out_valid  (out_valid[g]),
         .out_ready  (out_ready),
         .clear_ovf  (clear_ovf),
         .overflow   (overflow[g]),
         .busy       (busy[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Raise dot_done for one cycle; returns at the negedge after the capture edge.
   task automatic issue(input logic [31:0] d, input logic [31:0] b);
      @(negedge clk);
      dot_result = d;
      bias       = b;
      dot_done   = 1'b1;
      @(negedge clk);
      dot_done   = 1'b0;
   endtask

   task automatic pop_one();
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic run_vec(input string tag, input logic [31:0] d, input logic [31:0] b,
                          input logic [31:0] e_none, input logic [31:0] e_relu,
                          input logic [31:0] e_clamp);
      logic [31:0] exp_v [3];
      exp_v[0] = e_none;
      exp_v[1] = e_relu;
      exp_v[2] = e_clamp;
      issue(d, b);
      repeat (2) @(posedge clk);
      #1 check({tag, "_valid_t2"}, 32'(out_valid[1]), 32'd0);
      @(posedge clk);
      #1 check({tag, "_valid_t3"}, 32'(out_valid[1]), 32'd1);
      for (int k = 0; k < 3; k++)
         check($sformatf("%s_act%0d", tag, k), out_data[k], exp_v[k]);
      pop_one();
      check({tag, "_empty"}, 32'(out_valid[1]), 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      dot_done   = 1'b1;
      dot_result = 32'h0000_8000;
      bias       = 32'h0;
      out_ready  = 1'b0;
      clear_ovf  = 1'b0;
      #12;
      check("rst_valid",    32'(out_valid[1]), 32'd0);
      check("rst_data",     out_data[1],       32'd0);
      check("rst_overflow", 32'(overflow[1]),  32'd0);
      check("rst_busy",     32'(busy[1]),      32'd0);

      // dot_done high across reset release must not be captured
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1 check("held_busy",  32'(busy[1]),      32'd0);
      check("held_valid",    32'(out_valid[1]), 32'd0);
      @(negedge clk);
      dot_done = 1'b0;
      repeat (2) @(posedge clk);

      run_vec("v2m1",   32'h0001_0000, 32'h8000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000);
      run_vec("vm3p1",  32'h8001_8000, 32'h0000_8000, 32'h8001_0000, 32'h0000_0000, 32'h8000_8000);
      run_vec("vsatp",  32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_8000);
      run_vec("vsatn",  32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_8000);
      run_vec("vcancel",32'h0000_8000, 32'h8000_8000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
      run_vec("vnegz",  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
      run_vec("vp4",    32'h0002_0000, 32'h0000_0000, 32'h0002_0000, 32'h0002_0000, 32'h0000_8000);
      run_vec("vm4",    32'h8002_0000, 32'h0000_0000, 32'h8002_0000, 32'h0000_0000, 32'h8000_8000);
      run_vec("vsmall", 32'h0000_0001, 32'h8000_0003, 32'h8000_0002, 32'h0000_0000, 32'h8000_0002);

      // Five results into a four-entry FIFO with the consumer stalled
      for (int i = 1; i <= 5; i++) issue(32'(i), 32'h0);
      repeat (5) @(posedge clk);
      #1 check("ovf_set", 32'(overflow[1]), 32'd1);
      check("ovf_set_none", 32'(overflow[0]), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("drain_valid%0d", i), 32'(out_valid[1]), 32'd1);
         check($sformatf("drain_data%0d", i),  out_data[1],       32'(i));
         pop_one();
      end
      check("drain_empty", 32'(out_valid[1]), 32'd0);
      check("drain_hold",  out_data[1],       32'd4);
      check("ovf_sticky",  32'(overflow[1]),  32'd1);
      @(negedge clk);
      clear_ovf = 1'b1;
      @(negedge clk);
      clear_ovf = 1'b0;
      check("ovf_clear", 32'(overflow[1]), 32'd0);

      // Asynchronous reset while the FIFO holds data and S2 is valid
      issue(32'h0000_8000, 32'h0);
      repeat (3) @(posedge clk);
      issue(32'h0001_0000, 32'h0);
      repeat (2) @(posedge clk);
      #1 check("mid_busy_pre",  32'(busy[1]),      32'd1);
      check("mid_valid_pre",    32'(out_valid[1]), 32'd1);
      #2 rst_n = 1'b0;
      #1 check("mid_busy_rst",  32'(busy[1]),      32'd0);
      check("mid_valid_rst",    32'(out_valid[1]), 32'd0);
      check("mid_data_rst",     out_data[1],       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1 check("mid_valid_post", 32'(out_valid[1]), 32'd0);
      check("mid_busy_post",     32'(busy[1]),      32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
